// File: rtl/stride_pkg.sv
// rtl/stride_pkg.sv - shared encodings, state enum and helpers for the stride subsampler
package stride_pkg;

  localparam logic [1:0] STRIDE_SEL_1    = 2'd0;
  localparam logic [1:0] STRIDE_SEL_2    = 2'd1;
  localparam logic [1:0] STRIDE_SEL_4    = 2'd2;
  localparam logic [1:0] STRIDE_SEL_RSVD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } stride_state_e;

  // log2 of the effective stride; the reserved encoding falls back to bypass
  function automatic logic [1:0] stride_shift(input logic [1:0] sel);
    case (sel)
      STRIDE_SEL_2:                 return 2'd1;
      STRIDE_SEL_4:                 return 2'd2;
      STRIDE_SEL_1, STRIDE_SEL_RSVD: return 2'd0;
      default:                      return 2'd0;
    endcase
  endfunction

  // ceil(value / 2**shift) without a divider
  function automatic logic [31:0] ceil_shift(input logic [31:0] value, input logic [4:0] shift);
    return (value + ((32'd1 << shift) - 32'd1)) >> shift;
  endfunction

endpackage

// File: rtl/stride_sync_fifo.sv
// rtl/stride_sync_fifo.sv - first-word-fall-through synchronous FIFO with occupancy count
module stride_sync_fifo #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_BITS  = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic [ADDR_BITS:0]    count_o
);

  localparam int                   DEPTH      = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0]   FULL_COUNT = {1'b1, {ADDR_BITS{1'b0}}};
  localparam logic [ADDR_BITS-1:0] ONE_PTR    = 1;
  localparam logic [ADDR_BITS:0]   ONE_CNT    = 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_BITS-1:0]  wr_ptr_q;
  logic [ADDR_BITS-1:0]  rd_ptr_q;
  logic [ADDR_BITS:0]    count_q;
  logic                  do_wr;
  logic                  do_rd;

  // A read frees the slot a same-cycle write into a full FIFO needs
  assign do_rd     = rd_en_i && (count_q != '0);
  assign do_wr     = wr_en_i && ((count_q != FULL_COUNT) || do_rd);
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // Storage has no reset; pointers and count alone define valid contents
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push/pop leaves count unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + ONE_PTR;
      if (do_rd) rd_ptr_q <= rd_ptr_q + ONE_PTR;
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + ONE_CNT;
        2'b01:   count_q <= count_q - ONE_CNT;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/stride_subsample_stream.sv
// rtl/stride_subsample_stream.sv - runtime stride 1/2/4 subsampler with buffered output stream
module stride_subsample_stream
  import stride_pkg::*;
#(
  parameter int DATA_WIDTH            = 512,
  parameter int CH_PER_BEAT           = 8,
  parameter int WIDTH_FEATURE_SIZE    = 12,
  parameter int WIDTH_CHANNEL_NUM_REG = 10,
  parameter int FIFO_ADDR_BITS        = 9
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             Start,
  input  logic [1:0]                       Stride_REG,
  input  logic [WIDTH_FEATURE_SIZE-1:0]    Row_Num_In_REG,
  input  logic [WIDTH_FEATURE_SIZE-1:0]    Col_Num_In_REG,
  input  logic [WIDTH_CHANNEL_NUM_REG-1:0] Channel_In_Num_REG,
  input  logic [DATA_WIDTH-1:0]            S_Data,
  input  logic                             S_Valid,
  output logic                             S_Ready,
  output logic [DATA_WIDTH-1:0]            M_Data,
  output logic                             M_Valid,
  input  logic                             M_Ready,
  output logic                             M_Last,
  output logic                             Stride_Complete
);

  localparam int WFS      = WIDTH_FEATURE_SIZE;
  localparam int WCN      = WIDTH_CHANNEL_NUM_REG;
  localparam int CH_SHIFT = $clog2(CH_PER_BEAT);

  localparam logic [WFS-1:0] ONE_F = 1;
  localparam logic [WCN-1:0] ONE_C = 1;
  // Accept only while two slots are free: one for the beat already in the write register
  localparam logic [FIFO_ADDR_BITS:0] READY_MAX = {1'b0, {(FIFO_ADDR_BITS-1){1'b1}}, 1'b0};

  stride_state_e          state_q;
  logic [1:0]             shift_q;
  logic [WCN-1:0]         ct_last_q;
  logic [WFS-1:0]         col_last_q;
  logic [WFS-1:0]         row_last_q;
  logic [WFS-1:0]         ocol_last_q;
  logic [WFS-1:0]         orow_last_q;
  logic [WCN-1:0]         cin_q;
  logic [WFS-1:0]         col_q;
  logic [WFS-1:0]         row_q;
  logic [WCN-1:0]         o_cin_q;
  logic [WFS-1:0]         o_col_q;
  logic [WFS-1:0]         o_row_q;
  logic                   out_done_q;
  logic                   complete_q;
  logic                   wr_en_q;
  logic [DATA_WIDTH-1:0]  wr_data_q;
  logic [FIFO_ADDR_BITS:0] fifo_count;

  logic [1:0]     start_shift_d;
  logic [WCN-1:0] start_ct_d;
  logic [WFS-1:0] start_rout_d;
  logic [WFS-1:0] start_cout_d;
  logic           start_empty_d;

  logic [WFS-1:0] keep_mask;
  logic           keep;
  logic           in_fire;
  logic           out_fire;
  logic           cin_term;
  logic           col_term;
  logic           row_term;
  logic           in_last;
  logic           o_cin_term;
  logic           o_col_term;
  logic           o_row_term;

  // Frame geometry from the raw config inputs; only consumed on Start in IDLE
  always_comb begin
    start_shift_d = stride_shift(Stride_REG);
    start_ct_d    = WCN'(ceil_shift(32'(Channel_In_Num_REG), 5'(CH_SHIFT)));
    if (start_ct_d == '0) start_ct_d = ONE_C;
    start_rout_d  = WFS'(ceil_shift(32'(Row_Num_In_REG), {3'b000, start_shift_d}));
    start_cout_d  = WFS'(ceil_shift(32'(Col_Num_In_REG), {3'b000, start_shift_d}));
    start_empty_d = (Row_Num_In_REG == '0) || (Col_Num_In_REG == '0);
  end

  assign keep_mask = (ONE_F << shift_q) - ONE_F;
  assign keep      = ((col_q & keep_mask) == '0) && ((row_q & keep_mask) == '0);

  assign in_fire  = S_Valid && S_Ready;
  assign out_fire = M_Valid && M_Ready;

  assign cin_term   = (cin_q == ct_last_q);
  assign col_term   = (col_q == col_last_q);
  assign row_term   = (row_q == row_last_q);
  assign in_last    = cin_term && col_term && row_term;
  assign o_cin_term = (o_cin_q == ct_last_q);
  assign o_col_term = (o_col_q == ocol_last_q);
  assign o_row_term = (o_row_q == orow_last_q);

  assign S_Ready         = (state_q == ST_RUN) && (fifo_count <= READY_MAX);
  assign M_Valid         = (fifo_count != '0);
  assign M_Last          = M_Valid && o_cin_term && o_col_term && o_row_term;
  assign Stride_Complete = complete_q;

  // Frame FSM with config latch, input/output position counters and completion pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      ct_last_q   <= '0;
      col_last_q  <= '0;
      row_last_q  <= '0;
      ocol_last_q <= '0;
      orow_last_q <= '0;
      cin_q       <= '0;
      col_q       <= '0;
      row_q       <= '0;
      o_cin_q     <= '0;
      o_col_q     <= '0;
      o_row_q     <= '0;
      out_done_q  <= 1'b0;
      complete_q  <= 1'b0;
    end else begin
      complete_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            shift_q     <= start_shift_d;
            ct_last_q   <= start_ct_d - ONE_C;
            col_last_q  <= Col_Num_In_REG - ONE_F;
            row_last_q  <= Row_Num_In_REG - ONE_F;
            ocol_last_q <= start_cout_d - ONE_F;
            orow_last_q <= start_rout_d - ONE_F;
            cin_q       <= '0;
            col_q       <= '0;
            row_q       <= '0;
            o_cin_q     <= '0;
            o_col_q     <= '0;
            o_row_q     <= '0;
            // An empty frame has nothing to emit, so it is already fully drained
            out_done_q  <= start_empty_d;
            state_q     <= start_empty_d ? ST_DRAIN : ST_RUN;
          end
        end
        ST_RUN: begin
          if (in_fire && in_last) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (out_done_q || (out_fire && M_Last)) begin
            state_q    <= ST_IDLE;
            complete_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      if (in_fire) begin
        if (cin_term) begin
          cin_q <= '0;
          if (col_term) begin
            col_q <= '0;
            row_q <= row_term ? '0 : row_q + ONE_F;
          end else begin
            col_q <= col_q + ONE_F;
          end
        end else begin
          cin_q <= cin_q + ONE_C;
        end
      end

      // Trailing dropped rows can leave the output side finished while still in RUN
      if (out_fire) begin
        if (M_Last) out_done_q <= 1'b1;
        if (o_cin_term) begin
          o_cin_q <= '0;
          if (o_col_term) begin
            o_col_q <= '0;
            o_row_q <= o_row_term ? '0 : o_row_q + ONE_F;
          end else begin
            o_col_q <= o_col_q + ONE_F;
          end
        end else begin
          o_cin_q <= o_cin_q + ONE_C;
        end
      end
    end
  end

  // Kept beats pass through one register stage before entering the FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= in_fire && keep;
      if (in_fire && keep) wr_data_q <= S_Data;
    end
  end

  stride_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_BITS  (FIFO_ADDR_BITS)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en_q),
    .wr_data_i (wr_data_q),
    .rd_en_i   (M_Ready),
    .rd_data_o (M_Data),
    .count_o   (fifo_count)
  );

endmodule

// File: tb/tb_stride_subsample_stream.sv
// tb/tb_stride_subsample_stream.sv - directed-vector bench for stride_subsample_stream
module tb_stride_subsample_stream;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          Start;
  logic [1:0]    Stride_REG;
  logic [11:0]   Row_Num_In_REG;
  logic [11:0]   Col_Num_In_REG;
  logic [9:0]    Channel_In_Num_REG;
  logic [DW-1:0] S_Data;
  logic          S_Valid;
  logic          S_Ready;
  logic [DW-1:0] M_Data;
  logic          M_Valid;
  logic          M_Ready;
  logic          M_Last;
  logic          Stride_Complete;

  int checks = 0;
  int errors = 0;
  int complete_cnt = 0;
  int complete_early = 0;
  bit last_seen = 1'b0;
  int sent_cnt = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  stride_subsample_stream #(
    .DATA_WIDTH            (DW),
    .CH_PER_BEAT           (8),
    .WIDTH_FEATURE_SIZE    (12),
    .WIDTH_CHANNEL_NUM_REG (10),
    .FIFO_ADDR_BITS        (2)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .Start              (Start),
    .Stride_REG         (Stride_REG),
    .Row_Num_In_REG     (Row_Num_In_REG),
    .Col_Num_In_REG     (Col_Num_In_REG),
    .Channel_In_Num_REG (Channel_In_Num_REG),
    .S_Data             (S_Data),
    .S_Valid            (S_Valid),
    .S_Ready            (S_Ready),
    .M_Data             (M_Data),
    .M_Valid            (M_Valid),
    .M_Ready            (M_Ready),
    .M_Last             (M_Last),
    .Stride_Complete    (Stride_Complete)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] beat(input int tag, input int r, input int c, input int k);
    return {tag[7:0], r[7:0], c[7:0], k[7:0]};
  endfunction

  always @(negedge clk) begin
    if (Stride_Complete) begin
      complete_cnt++;
      if (!last_seen) complete_early++;
    end
  end

  task automatic start_frame(input logic [1:0] s, input int r, input int c, input int ch);
    @(negedge clk);
    Stride_REG         = s;
    Row_Num_In_REG     = 12'(r);
    Col_Num_In_REG     = 12'(c);
    Channel_In_Num_REG = 10'(ch);
    Start              = 1'b1;
    @(negedge clk);
    Start              = 1'b0;
    Stride_REG         = 2'd0;
    Row_Num_In_REG     = '0;
    Col_Num_In_REG     = '0;
    Channel_In_Num_REG = '0;
  endtask

  task automatic producer(input int tag, input int r, input int c, input int ct, input int vprob);
    for (int rr = 0; rr < r; rr++) begin
      for (int cc = 0; cc < c; cc++) begin
        for (int kk = 0; kk < ct; kk++) begin
          int guard;
          bit done;
          guard = 0;
          done  = 1'b0;
          while (!done && guard < 2000) begin
            @(negedge clk);
            S_Valid = ($urandom_range(99, 0) < vprob);
            S_Data  = beat(tag, rr, cc, kk);
            if (S_Valid && S_Ready) begin
              done = 1'b1;
              sent_cnt++;
            end
            guard++;
          end
          if (!done) begin
            check_value("producer_timeout", 32'd0, 32'd1);
            S_Valid = 1'b0;
            return;
          end
        end
      end
    end
    @(negedge clk);
    S_Valid = 1'b0;
  endtask

  task automatic consumer(input string name, input int rprob, input int stall, input int n_hand);
    int got;
    int cyc;
    int extra;
    got = 0;
    cyc = 0;
    extra = 0;
    while (got < n_hand && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      M_Ready = (cyc > stall) && ($urandom_range(99, 0) < rprob);
      if (stall > 0 && cyc == stall) begin
        check_value({name, "_accepted_stalled"}, sent_cnt, 32'd4);
        check_value({name, "_ready_stalled"}, S_Ready, 32'd0);
        check_value({name, "_valid_stalled"}, M_Valid, 32'd1);
      end
      if (M_Valid && M_Ready) begin
        if (got < exp_q.size()) check_value({name, "_data"}, M_Data, exp_q[got]);
        check_value({name, "_last"}, M_Last, (got == n_hand - 1));
        if (M_Last) last_seen = 1'b1;
        got++;
      end
    end
    check_value({name, "_beats"}, got, n_hand);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      M_Ready = 1'b1;
      if (M_Valid) extra++;
    end
    check_value({name, "_extra"}, extra, 32'd0);
  endtask

  task automatic run_frame(input string name, input int tag, input logic [1:0] s,
                           input int r, input int c, input int ch,
                           input int vprob, input int rprob, input int stall, input int n_hand);
    int ct;
    int st;
    int c0;
    ct = (ch == 0) ? 1 : (ch + 7) / 8;
    st = (s == 2'd1) ? 2 : ((s == 2'd2) ? 4 : 1);
    exp_q.delete();
    for (int rr = 0; rr < r; rr++)
      for (int cc = 0; cc < c; cc++)
        for (int kk = 0; kk < ct; kk++)
          if ((rr % st) == 0 && (cc % st) == 0) exp_q.push_back(beat(tag, rr, cc, kk));
    last_seen      = (exp_q.size() == 0);
    c0             = complete_cnt;
    complete_early = 0;
    sent_cnt       = 0;
    M_Ready        = 1'b0;
    start_frame(s, r, c, ch);
    fork
      producer(tag, r, c, ct, vprob);
      consumer(name, rprob, stall, n_hand);
    join
    for (int i = 0; i < 200 && complete_cnt == c0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    check_value({name, "_complete"}, complete_cnt - c0, 32'd1);
    check_value({name, "_early_complete"}, complete_early, 32'd0);
    check_value({name, "_idle_ready"}, S_Ready, 32'd0);
    check_value({name, "_sent"}, sent_cnt, r * c * ct);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int c0;
    rst                = 1'b1;
    Start              = 1'b0;
    Stride_REG         = 2'd0;
    Row_Num_In_REG     = '0;
    Col_Num_In_REG     = '0;
    Channel_In_Num_REG = '0;
    S_Data             = '0;
    S_Valid            = 1'b0;
    M_Ready            = 1'b0;
    repeat (3) @(negedge clk);
    check_value("rst_s_ready", S_Ready, 32'd0);
    check_value("rst_m_valid", M_Valid, 32'd0);
    check_value("rst_m_last", M_Last, 32'd0);
    check_value("rst_complete", Stride_Complete, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_value("idle_s_ready", S_Ready, 32'd0);

    run_frame("s1",    1, 2'd0, 4, 4, 16, 100, 100,  0, 32);
    run_frame("s2",    2, 2'd1, 5, 5,  8, 100, 100,  0,  9);
    run_frame("s4",    3, 2'd2, 8, 6, 24, 100, 100,  0, 12);
    run_frame("bp",    4, 2'd0, 2, 4,  8, 100, 100, 20,  8);
    run_frame("rnd",   5, 2'd1, 7, 7, 40,  50,  50,  0, 80);
    run_frame("rsv",   6, 2'd3, 2, 3,  8,  70,  60,  0,  6);
    run_frame("empty", 7, 2'd1, 0, 4,  8, 100, 100,  0,  0);

    // Abort a frame with buffered beats through the asynchronous reset
    M_Ready = 1'b0;
    start_frame(2'd0, 4, 4, 8);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      S_Valid = 1'b1;
      S_Data  = beat(9, 0, i, 0);
    end
    @(negedge clk);
    S_Valid = 1'b0;
    check_value("pre_rst_m_valid", M_Valid, 32'd1);
    c0 = complete_cnt;
    rst = 1'b1;
    #1;
    check_value("mid_rst_s_ready", S_Ready, 32'd0);
    check_value("mid_rst_m_valid", M_Valid, 32'd0);
    check_value("mid_rst_m_last", M_Last, 32'd0);
    check_value("mid_rst_complete", Stride_Complete, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check_value("mid_rst_no_complete", complete_cnt - c0, 32'd0);
    check_value("mid_rst_no_valid", M_Valid, 32'd0);

    run_frame("post_rst", 8, 2'd1, 5, 5, 8, 100, 100, 0, 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
